// File: rtl/fifo_param_if.sv
// ----------------------------------------------------------------------------
// fifo_param_if
//   Bundles the producer/consumer side of fifo_param into one interface.
//   master : the user of the FIFO. It drives flush/write/data_in/read and
//            observes the data and status outputs.
//   slave  : the FIFO itself.
//   Signals:
//     flush        synchronous clear of contents and flags
//     write        push data_in this cycle
//     data_in      write data, WIDTH bits
//     read         pop the head entry this cycle
//     data_out     head entry (show-ahead), 0 while the FIFO is empty
//     ready        FIFO not empty
//     full         occupancy == DEPTH
//     almost_full  occupancy >= AF_LEVEL
//     almost_empty occupancy <= AE_LEVEL
//     count        occupancy, 0..DEPTH
//     overflow     sticky: a write was rejected
//     underflow    sticky: a read was rejected
// ----------------------------------------------------------------------------
interface fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             write;
    logic [WIDTH-1:0] data_in;
    logic             read;
    logic [WIDTH-1:0] data_out;
    logic             ready;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, write, data_in, read,
        input  data_out, ready, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, write, data_in, read,
        output data_out, ready, full, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// ----------------------------------------------------------------------------
// fifo_param
//   Parametrised single-clock show-ahead FIFO. All DEPTH entries are usable;
//   the pointers carry one extra MSB so full and empty can be told apart.
//   The head entry is presented on data_out combinationally; a read pops it
//   at the clock edge. All status outputs are derived from registered state
//   only, so there is no combinational path from read/write to the flags.
//   Ports:
//     clk    rising-edge clock
//     clrn   asynchronous reset, active low
//     bus    fifo_param_if.slave: flush/write/data_in/read in,
//            data_out/ready/full/almost_*/count/overflow/underflow out
// ----------------------------------------------------------------------------
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic          clk,
    input  logic          clrn,
    fifo_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [PW-1:0] count;
    logic          full;
    logic          ready;
    logic          rd_acc;
    logic          wr_acc;
    logic          wr_rej;
    logic          rd_rej;
    logic          mem_we;

    // With power-of-two DEPTH the pointer difference is the occupancy,
    // including the full case where the MSBs differ and the addresses match.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == DEPTH_C);
    assign ready = (count != '0);

    // A full FIFO can still take a write when a read frees a slot the same cycle.
    assign rd_acc = bus.read && ready;
    assign wr_acc = bus.write && (!full || rd_acc);
    assign wr_rej = bus.write && !wr_acc;
    assign rd_rej = bus.read && !ready;
    assign mem_we = wr_acc && !bus.flush;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // this block leaves it unassigned, which would infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);

            // Set wins over clear on both sticky flags.
            if (wr_rej)      overflow_d = 1'b1;
            else if (rd_acc) overflow_d = 1'b0;

            if (rd_rej)      underflow_d = 1'b1;
            else if (wr_acc) underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!clrn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; contents are only observable
    // through data_out while ready=1, and a reset would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= bus.data_in;
    end

    assign bus.data_out     = ready ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign bus.ready        = ready;
    assign bus.full         = full;
    assign bus.almost_full  = (count >= AF_C);
    assign bus.almost_empty = (count <= AE_C);
    assign bus.count        = count;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
